// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects, FSM states
// and the packed control word driven by the state decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    ADDI_EX  = 4'd8,
    ADDI_WB  = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control-word decode. Memory-state strobes that commit
// (IR/PC load, store completion) are qualified by mem_ready; reset forces an all-zero word.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) ctrl = '0;
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, flags illegal opcodes and counts retired instructions.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  ctrl_t            ctrl;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  mips_mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (ctrl.instr_done) retired_q <= retired_q + CNT_W'(1);
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= RTYPE_EX;
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            OP_ADDI:      state <= ADDI_EX;
            default: begin
              // Unknown opcode: abandon the instruction, keep running.
              state     <= FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        MEM_ADDR: state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state <= MEM_WB;
        MEM_WR:   if (mem_ready) state <= FETCH;
        RTYPE_EX: state <= RTYPE_WB;
        ADDI_EX:  state <= ADDI_WB;
        default:  state <= FETCH;
      endcase
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  // Registered status is masked so every output reads zero while reset is held.
  assign illegal_op    = illegal_q & ~reset;
  assign retired       = reset ? '0 : retired_q;

endmodule
